tmds_video_source: RTL
======================

// Module: tmds_video_source
// PURPOSE
//  Transmit-side counterpart of the capture path's control-token/pvalid/vsync detector and TMDS decoders.
//  Generates video timing from parameters and requests pixels.
//  Emits per-channel 10-bit TMDS words in the same 30-bit layout the capture path consumes:
//  control tokens in blanking, preamble plus 2-cycle guard band before each active line, DC-balanced TMDS data in active video.
//  Drives the serializer side or loops back into the capture pipeline for self-test.
// PARAMETERS
//  H_ACTIVE   1280  active pixels per line
//  H_FP       110   horizontal front porch (cycles)
//  H_SYNC     40    hsync width
//  H_BP       220   back porch; must be >= PREAMBLE+GUARD
//  V_ACTIVE   720   active lines
//  V_FP       5     vertical front porch (lines)
//  V_SYNC     5     vsync width
//  V_BP       20    vertical back porch
//  HSYNC_POL  1     1: hsync bit high while asserted
//  VSYNC_POL  1     1: vsync bit high while asserted
//  PREAMBLE   8     preamble length (cycles)
//  GUARD      2     guard-band length (cycles)
// PORTS
//  clk          in   1   pixel clock
//  rst_n        in   1   asynchronous active-low reset
//  en           in   1   run timing; low = hold counters at 0
//  pix_req      out  1   pixel accepted this cycle (active region)
//  pix_rgb      in   24  {R,G,B}; sampled on the cycle pix_req is high
//  frame_start  out  1   1-cycle pulse at hcnt=0,vcnt=0 (input stage)
//  data         out  30  {ch2(R),ch1(G),ch0(B)}; 10 bits each, bit0 = first serial bit
//  valid        out  1   data meaningful (en pipeline-delayed)
// BEHAVIOUR
//  Reset: counters 0, pipeline cleared, disparity 0.
//   Reset values: pix_req=0, frame_start=0, valid=0, data={3{CTLTKN0}}.
//  Counters:
//   hcnt 0..H_TOTAL-1; vcnt 0..V_TOTAL-1, incremented when hcnt wraps.
//   H_BLANK=H_FP+H_SYNC+H_BP; V_BLANK likewise; H_TOTAL=H_BLANK+H_ACTIVE.
//   Order per line: FP, SYNC, BP, then active.
//   hs = hcnt in [H_FP, H_FP+H_SYNC); vs = vcnt in [V_FP, V_FP+V_SYNC).
//   Wire bit = hs^~HSYNC_POL, vs^~VSYNC_POL.
//   de = vcnt>=V_BLANK && hcnt>=H_BLANK; pix_req=de&en (combinational from counters).
//  Period select (per cycle, input stage):
//   CTRL: default.
//   PRE: vcnt>=V_BLANK && hcnt in [H_BLANK-PREAMBLE-GUARD, H_BLANK-GUARD).
//   GUARD: hcnt in [H_BLANK-GUARD, H_BLANK) on active lines.
//   DATA: de.
//  Channel words (token index = {C1,C0}):
//   00 1101010100, 01 0010101011, 10 0101010100, 11 1010101011.
//   CTRL: ch0 token {vsbit,hsbit}; ch1, ch2 token 00.
//   PRE: ch0 as CTRL; ch1 token 01; ch2 token 00.
//   GUARD: ch0 1011001100, ch1 0100110011, ch2 1011001100.
//   DATA: standard DVI 8b/10b per channel.
//    Stage 1: transition-minimise to q_m[8:0].
//    Stage 2: DC balance using signed 5-bit running disparity per channel.
//    Disparity forced to 0 in any non-DATA cycle.
//  Latency: 3 cycles fixed from counter state/pix_rgb sample to data.
//   Control, preamble and guard words are delayed through the same pipeline, so periods stay aligned.
//  en low: counters held at 0 (front porch); pix_req=0.
//   Pipeline keeps shifting, so output drains to CTRL tokens.
//   valid falls 3 cycles after en.
//  en rising: timing starts at hcnt=0,vcnt=0.
//   frame_start pulses that cycle and on every later frame wrap.
//  Async reset mid-line: all state cleared immediately; restart as from reset on deassertion.
//  Parameter check: H_BP<PREAMBLE+GUARD is a fatal elaboration error.
// TESTING
//  Small config for all scenarios:
//   H_ACTIVE=4, H_FP=2, H_SYNC=2, H_BP=12, V_ACTIVE=2, V_FP=1, V_SYNC=1, V_BP=1, both POL=1 (H_TOTAL=20, V_TOTAL=5).
//  1 Reset/idle: rst_n=0 then en=0 for 50 cycles
//    -> data=={3{1101010100}}, valid=0, pix_req=0, frame_start=0 throughout.
//  2 Blank line: en=1, capture line vcnt=1 (vsync line)
//    -> ch0 = 0101010100 at hcnt 0,1,4..19 and 1010101011 at hcnt 2,3 (3 cycles later);
//       ch1 = ch2 = 1101010100; pix_req never high.
//  3 Active-line lead-in: line vcnt=3
//    -> ch1 = 0010101011 for hcnt 6..13; guard words on all channels at hcnt 14,15;
//       pix_req high exactly at hcnt 16..19.
//  4 Encoding: pix_rgb=0 on 4 consecutive pixels
//    -> each channel 0100000000, 1111111111, 0100000000, 1111111111 (disparity 0,-8,+2,-6,+4).
//  5 Disparity reset: line ends mid-sequence (disparity nonzero); next line first pixel 0x00
//    -> 0100000000 again.
//  6 Control/reset: en drops mid-active line
//    -> valid low 3 cycles later, CTRL tokens thereafter.
//   Async rst_n pulse mid-pixel
//    -> immediate {3{CTLTKN0}}; restart yields frame_start on first en cycle.

Source files
------------

// File: rtl/tmds_video_source.sv
// Timing generator and three-channel TMDS encoder producing control, preamble,
// guard-band and DC-balanced pixel words with a fixed three-cycle pipeline.
module tmds_video_source #(
  parameter int unsigned H_ACTIVE  = 1280,
  parameter int unsigned H_FP      = 110,
  parameter int unsigned H_SYNC    = 40,
  parameter int unsigned H_BP      = 220,
  parameter int unsigned V_ACTIVE  = 720,
  parameter int unsigned V_FP      = 5,
  parameter int unsigned V_SYNC    = 5,
  parameter int unsigned V_BP      = 20,
  parameter bit          HSYNC_POL = 1'b1,
  parameter bit          VSYNC_POL = 1'b1,
  parameter int unsigned PREAMBLE  = 8,
  parameter int unsigned GUARD     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic        pix_req,
  input  logic [23:0] pix_rgb,
  output logic        frame_start,
  output logic [29:0] data,
  output logic        valid
);

  localparam int unsigned H_BLANK     = H_FP + H_SYNC + H_BP;
  localparam int unsigned V_BLANK     = V_FP + V_SYNC + V_BP;
  localparam int unsigned H_TOTAL     = H_BLANK + H_ACTIVE;
  localparam int unsigned V_TOTAL     = V_BLANK + V_ACTIVE;
  localparam int unsigned HW          = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int unsigned VW          = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
  localparam int unsigned PRE_START   = H_BLANK - PREAMBLE - GUARD;
  localparam int unsigned GUARD_START = H_BLANK - GUARD;

  localparam logic [9:0] CTL_TKN0 = 10'b1101010100;
  localparam logic [9:0] CTL_TKN1 = 10'b0010101011;
  localparam logic [9:0] CTL_TKN2 = 10'b0101010100;
  localparam logic [9:0] CTL_TKN3 = 10'b1010101011;
  localparam logic [9:0] GB_CH02  = 10'b1011001100;
  localparam logic [9:0] GB_CH1   = 10'b0100110011;

  typedef enum logic [1:0] {PER_CTRL, PER_PRE, PER_GUARD, PER_DATA} period_e;

  if (H_BP < PREAMBLE + GUARD) begin : g_param_check
    $fatal(1, "tmds_video_source: H_BP must be >= PREAMBLE + GUARD");
  end

  function automatic logic [9:0] ctl_token(input logic [1:0] c);
    case (c)
      2'b00:   return CTL_TKN0;
      2'b01:   return CTL_TKN1;
      2'b10:   return CTL_TKN2;
      default: return CTL_TKN3;
    endcase
  endfunction

  // First 8b/10b stage: XOR or XNOR chain, whichever gives fewer transitions
  function automatic logic [8:0] tm_min(input logic [7:0] d);
    logic [8:0] q;
    logic       use_xnor;
    use_xnor = ($countones(d) > 4) || (($countones(d) == 4) && !d[0]);
    q = '0;
    q[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    end
    q[8] = ~use_xnor;
    return q;
  endfunction

  // Second stage: returns {next_disparity, word}
  function automatic logic [14:0] dc_balance(input logic [8:0] qm, input logic signed [4:0] cnt);
    logic signed [4:0] bal;
    logic signed [4:0] nxt;
    logic [9:0]        w;
    bal = $signed(5'($countones(qm[7:0])) << 1) - 5'sd8;
    if (cnt == 5'sd0 || bal == 5'sd0) begin
      w   = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      nxt = qm[8] ? cnt + bal : cnt - bal;
    end else if ((cnt > 5'sd0) == (bal > 5'sd0)) begin
      w   = {1'b1, qm[8], ~qm[7:0]};
      nxt = cnt - bal + (qm[8] ? 5'sd2 : 5'sd0);
    end else begin
      w   = {1'b0, qm[8], qm[7:0]};
      nxt = cnt + bal - (qm[8] ? 5'sd0 : 5'sd2);
    end
    return {nxt, w};
  endfunction

  logic [HW-1:0]    hcnt;
  logic [VW-1:0]    vcnt;
  logic             hs, vs, active_line, de;
  period_e          period_c;
  logic [1:0]       ctl_c;
  period_e          s1_period, s2_period;
  logic [1:0]       s1_ctl, s2_ctl;
  logic [23:0]      s1_rgb;
  logic [2:0][8:0]  s2_qm;
  logic             en_d1, en_d2;
  logic [2:0][4:0]  disp, disp_nxt;
  logic [2:0][14:0] res;
  logic [29:0]      data_nxt;

  // Frame counters; held at the frame origin while disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (!en) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (hcnt == HW'(H_TOTAL - 1)) begin
      hcnt <= '0;
      vcnt <= (vcnt == VW'(V_TOTAL - 1)) ? '0 : vcnt + VW'(1);
    end else begin
      hcnt <= hcnt + HW'(1);
    end
  end

  always_comb begin
    hs          = (hcnt >= HW'(H_FP)) && (hcnt < HW'(H_FP + H_SYNC));
    vs          = (vcnt >= VW'(V_FP)) && (vcnt < VW'(V_FP + V_SYNC));
    active_line = vcnt >= VW'(V_BLANK);
    de          = active_line && (hcnt >= HW'(H_BLANK));
    pix_req     = de && en;
    frame_start = en && rst_n && (hcnt == '0) && (vcnt == '0);
    ctl_c       = en ? {vs ^ ~VSYNC_POL, hs ^ ~HSYNC_POL} : 2'b00;
    period_c    = PER_CTRL;
    if (en) begin
      if (de)                                              period_c = PER_DATA;
      else if (active_line && hcnt >= HW'(GUARD_START))    period_c = PER_GUARD;
      else if (active_line && hcnt >= HW'(PRE_START))      period_c = PER_PRE;
    end
  end

  // Stages 1 and 2: capture input, then transition-minimise each channel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_period <= PER_CTRL;
      s1_ctl    <= 2'b00;
      s1_rgb    <= '0;
      s2_period <= PER_CTRL;
      s2_ctl    <= 2'b00;
      s2_qm     <= '0;
      en_d1     <= 1'b0;
      en_d2     <= 1'b0;
    end else begin
      s1_period <= period_c;
      s1_ctl    <= ctl_c;
      s1_rgb    <= pix_rgb;
      s2_period <= s1_period;
      s2_ctl    <= s1_ctl;
      for (int c = 0; c < 3; c++) begin
        s2_qm[c] <= tm_min(s1_rgb[8*c +: 8]);
      end
      en_d1 <= en;
      en_d2 <= en_d1;
    end
  end

  always_comb begin
    disp_nxt = '0;
    for (int c = 0; c < 3; c++) begin
      res[c] = dc_balance(s2_qm[c], $signed(disp[c]));
    end
    case (s2_period)
      PER_DATA: begin
        data_nxt = {res[2][9:0], res[1][9:0], res[0][9:0]};
        for (int c = 0; c < 3; c++) begin
          disp_nxt[c] = res[c][14:10];
        end
      end
      PER_GUARD: data_nxt = {GB_CH02, GB_CH1, GB_CH02};
      PER_PRE:   data_nxt = {CTL_TKN0, CTL_TKN1, ctl_token(s2_ctl)};
      default:   data_nxt = {CTL_TKN0, CTL_TKN0, ctl_token(s2_ctl)};
    endcase
  end

  // Stage 3: output word and running disparity
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data  <= {3{CTL_TKN0}};
      disp  <= '0;
      valid <= 1'b0;
    end else begin
      data  <= data_nxt;
      disp  <= disp_nxt;
      valid <= en_d2;
    end
  end

endmodule
